div_reconstructor: RTL



---
 rtl/div_pkg.sv | 25 ++
 rtl/div_reconstructor_mul_step.sv | 34 +++
 rtl/div_reconstructor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider / reconstructor pair.
//   N_DEF      default operand width
//   CNT_W_DEF  step-counter width for the default operand width
//   state_t    reconstructor FSM encoding (IDLE / RUN / DONE)
//   cnt_w()    counter width for an arbitrary operand width (never below 1)
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int N_DEF     = 4;
   localparam int CNT_W_DEF = $clog2(N_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // $clog2(1) is 0, which cannot size a register; keep at least one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_reconstructor_mul_step.sv
// -----------------------------------------------------------------------------
// mul_step
// One shift-add iteration of the reconstructor. Purely combinational.
//   acc      in   2N   running accumulator
//   b        in   N    multiplicand (divisor)
//   m_lsb    in   1    current multiplier bit
//   count    in   CNT_W  step index, i.e. weight of the current multiplier bit
//   acc_nxt  out  2N   accumulator after this step
// The shifted multiplicand is at most (2^N-1)*2^(N-1), so the 2N-bit sum
// never wraps given the accumulator starts from an N-bit remainder.
// -----------------------------------------------------------------------------
module mul_step
   import div_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic [2*N-1:0]   acc,
   input  logic [N-1:0]     b,
   input  logic             m_lsb,
   input  logic [CNT_W-1:0] count,
   output logic [2*N-1:0]   acc_nxt
);

   logic [2*N-1:0] addend;

   always_comb begin
      addend  = '0;
      if (m_lsb)
         addend = {{N{1'b0}}, b} << count;
      acc_nxt = acc + addend;
   end

endmodule

// File: rtl/div_reconstructor.sv
// -----------------------------------------------------------------------------
// div_reconstructor
// Sequential shift-add unit that rebuilds a dividend from a divider result:
// a = m*b + r. Sits behind the divider so its output can be compared with the
// original dividend. Fixed latency: N steps regardless of operand values.
//
// Ports
//   clk      in   1    rising-edge clock
//   rst      in   1    asynchronous reset, active low
//   m        in   N    quotient, sampled on an accepted start
//   b        in   N    divisor, sampled on an accepted start
//   r        in   N    remainder, sampled on an accepted start
//   start    in   1    request; accepted whenever no computation is running
//   a        out  2N   reconstructed value, held until the next result
//   ovf      out  1    result exceeds N bits (|a[2N-1:N]), updated with a
//   busy     out  1    computation in progress
//   valid    out  1    one-cycle pulse marking a fresh a/ovf
//   rem_err  out  1    (DIV_RECON_REM_CHECK_EN only) captured r >= captured b
//
// Optional feature: define DIV_RECON_REM_CHECK_EN to add the rem_err output,
// which flags an inconsistent divider result (remainder not below divisor;
// a zero divisor therefore always flags).
//
// Timing: accept on edge E0, steps on E1..EN, result and valid after EN.
// Start presented during DONE is accepted directly, giving one result every
// N+1 cycles back to back.
// -----------------------------------------------------------------------------
module div_reconstructor
   import div_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   m,
   input  logic [N-1:0]   b,
   input  logic [N-1:0]   r,
   input  logic           start,
   output logic [2*N-1:0] a,
   output logic           ovf,
   output logic           busy,
   output logic           valid
`ifdef DIV_RECON_REM_CHECK_EN
   ,
   output logic           rem_err
`endif
);

   localparam int CNT_W = cnt_w(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   state_t           state, state_nxt;
   logic [N-1:0]     mplier;   // quotient, consumed LSB first
   logic [N-1:0]     mcand;    // divisor, held for the whole run
   logic [2*N-1:0]   acc;
   logic [CNT_W-1:0] count;
   logic [2*N-1:0]   acc_nxt;

   logic accept;
   logic last_step;

`ifdef DIV_RECON_REM_CHECK_EN
   // Consistency verdict is taken at capture time, since r is folded into
   // the accumulator and no longer visible once stepping starts.
   logic rem_flag;
`endif

   // Only RUN blocks a new request; DONE accepts so results can chain.
   assign accept    = start && (state != RUN);
   assign last_step = (state == RUN) && (count == LAST_CNT);

   mul_step #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_step (
      .acc     (acc),
      .b       (mcand),
      .m_lsb   (mplier[0]),
      .count   (count),
      .acc_nxt (acc_nxt)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // valid and busy decode disjoint states, so they can never overlap.
   always_comb begin
      busy  = 1'b0;
      valid = 1'b0;
      case (state)
         RUN:     busy  = 1'b1;
         DONE:    valid = 1'b1;
         default: ;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mplier <= '0;
         mcand  <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (accept) begin
         mplier <= m;
         mcand  <= b;
         acc    <= {{N{1'b0}}, r};
         count  <= '0;
      end else if (state == RUN) begin
         acc    <= acc_nxt;
         mplier <= mplier >> 1;
         count  <= count + CNT_W'(1);
      end
   end

   // Result registers load only on the final step, so a reset mid-run leaves
   // them at zero and an in-flight operation never reaches the outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a   <= '0;
         ovf <= 1'b0;
      end else if (last_step) begin
         a   <= acc_nxt;
         ovf <= |acc_nxt[2*N-1:N];
      end
   end

`ifdef DIV_RECON_REM_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_flag <= 1'b0;
         rem_err  <= 1'b0;
      end else begin
         if (accept)
            rem_flag <= (r >= b);
         if (last_step)
            rem_err  <= rem_flag;
      end
   end
`endif

endmodule
